// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// byte-enable and store-data helpers, and the legality check.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } lsu_state_t;

    // Access size lives in funct3[1:0] for both loads and stores.
    function automatic logic [3:0] be_for(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'd0:    be_for = 4'b0001 << off;
            2'd1:    be_for = 4'b0011 << off;
            default: be_for = 4'hF;
        endcase
    endfunction

    // Replicate store data across all lanes so the byte enables pick the lane.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            F3_SB:   store_wdata = {4{w[7:0]}};
            F3_SH:   store_wdata = {2{w[15:0]}};
            default: store_wdata = w;
        endcase
    endfunction

    function automatic logic op_illegal(input logic is_load, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic bad_f3;
        logic misal;
        if (is_load)
            bad_f3 = !(f3 == F3_LB || f3 == F3_LH || f3 == F3_LW ||
                       f3 == F3_LBU || f3 == F3_LHU);
        else
            bad_f3 = !(f3 == F3_SB || f3 == F3_SH || f3 == F3_SW);
        misal = (f3[1:0] == 2'd1 && off[0]) || (f3[1:0] == 2'd2 && off != 2'd0);
        return bad_f3 || misal;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data formatter: shifts the addressed lane down and sign/zero-extends.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int width = 32
) (
    input  logic [2:0]       funct3_i,
    input  logic [1:0]       off_i,
    input  logic [width-1:0] rdata_i,
    output logic [width-1:0] data_o
);

    logic [width-1:0] s;

    // Lane shift followed by extension selected by funct3.
    always_comb begin
        s = rdata_i >> {off_i, 3'b000};
        case (funct3_i)
            F3_LB:   data_o = {{(width-8){s[7]}}, s[7:0]};
            F3_LBU:  data_o = {{(width-8){1'b0}}, s[7:0]};
            F3_LH:   data_o = {{(width-16){s[15]}}, s[15:0]};
            F3_LHU:  data_o = {{(width-16){1'b0}}, s[15:0]};
            default: data_o = s;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one outstanding word-aligned bus access per op,
// registered bus outputs and a one-cycle writeback pulse for loads.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_is_load,
    input  logic [2:0]       req_funct3,
    input  logic [width-1:0] req_addr,
    input  logic [width-1:0] req_wdata,
    input  logic [4:0]       req_rd,
    output logic             mem_req,
    output logic             mem_we,
    output logic [width-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [width-1:0] mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [width-1:0] mem_rdata,
    output logic             wr_en,
    output logic [4:0]       rd,
    output logic [width-1:0] ld_data,
    output logic             is_load,
    output logic             exc
);

    lsu_state_t       state_q;
    logic             req_ready_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [width-1:0] mem_addr_q;
    logic [3:0]       mem_be_q;
    logic [width-1:0] mem_wdata_q;
    logic             wr_en_q;
    logic [4:0]       rd_q;
    logic [width-1:0] ld_data_q;
    logic             is_load_q;
    logic             exc_q;

    // Attributes of the in-flight op, needed when the response returns.
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic             op_load_q;
    logic [4:0]       op_rd_q;

    logic             accept;
    logic [1:0]       req_off;
    logic [width-1:0] align_data;

    assign accept  = req_valid && req_ready_q;
    assign req_off = req_addr[1:0];

    lsu_load_align #(.width(width)) u_align (
        .funct3_i (f3_q),
        .off_i    (off_q),
        .rdata_i  (mem_rdata),
        .data_o   (align_data)
    );

    // FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            wr_en_q     <= 1'b0;
            rd_q        <= '0;
            ld_data_q   <= '0;
            is_load_q   <= 1'b0;
            exc_q       <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            op_load_q   <= 1'b0;
            op_rd_q     <= '0;
        end else begin
            wr_en_q   <= 1'b0;
            is_load_q <= 1'b0;
            exc_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        if (op_illegal(req_is_load, req_funct3, req_off)) begin
                            exc_q <= 1'b1;
                        end else begin
                            state_q     <= REQ;
                            req_ready_q <= 1'b0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= !req_is_load;
                            mem_addr_q  <= {req_addr[width-1:2], 2'b00};
                            mem_be_q    <= be_for(req_funct3, req_off);
                            mem_wdata_q <= store_wdata(req_funct3, req_wdata);
                            f3_q        <= req_funct3;
                            off_q       <= req_off;
                            op_load_q   <= req_is_load;
                            op_rd_q     <= req_rd;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        state_q   <= WAIT;
                        mem_req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        if (op_load_q) begin
                            wr_en_q   <= 1'b1;
                            is_load_q <= 1'b1;
                            rd_q      <= op_rd_q;
                            ld_data_q <= align_data;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign wr_en     = wr_en_q;
    assign rd        = rd_q;
    assign ld_data   = ld_data_q;
    assign is_load   = is_load_q;
    assign exc       = exc_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver pushes expected bus
// requests, writebacks and exceptions; a negedge monitor pops and compares.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_load = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wr_en;
    logic [4:0]  rd;
    logic [31:0] ld_data;
    logic        is_load;
    logic        exc;

    always #5 clk = ~clk;

    load_store_unit #(.width(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_is_load (req_is_load),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rd      (req_rd),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .wr_en       (wr_en),
        .rd          (rd),
        .ld_data     (ld_data),
        .is_load     (is_load),
        .exc         (exc)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
    } bus_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    bus_t exp_bus[$];
    wb_t  exp_wb[$];
    int   exp_exc = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare every bus request, writeback and exception against the queues.
    logic prev_req = 1'b0;
    bus_t mb;
    wb_t  mw;
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req && !prev_req) begin
                if (exp_bus.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mem_req: addr 0x%08h", mem_addr);
                end else begin
                    mb = exp_bus.pop_front();
                    chk("bus_we", mem_we, mb.we);
                    chk("bus_addr", mem_addr, mb.addr);
                    chk("bus_be", mem_be, mb.be);
                    if (mb.chk_wdata) chk("bus_wdata", mem_wdata, mb.wdata);
                end
            end
            if (wr_en) begin
                if (exp_wb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wr_en: rd %0d data 0x%08h", rd, ld_data);
                end else begin
                    mw = exp_wb.pop_front();
                    chk("wb_rd", rd, mw.rd);
                    chk("wb_data", ld_data, mw.data);
                    chk("wb_is_load", is_load, 1);
                end
            end
            if (exc) begin
                if (exp_exc == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_exc: got 1 expected 0");
                end else begin
                    exp_exc--;
                    chk("exc_no_mem_req", mem_req, 0);
                end
            end
        end
        prev_req <= mem_req;
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_timeout", req_ready, 1);
    endtask

    task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rdn);
        req_is_load = ld;
        req_funct3  = f3;
        req_addr    = addr;
        req_wdata   = wdata;
        req_rd      = rdn;
        req_valid   = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rdn,
                         input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                         input logic e_exc, input logic [3:0] e_be,
                         input logic [31:0] e_wdata, input logic [31:0] e_ld);
        bus_t b;
        wb_t  w;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic [3:0]  s_be;
        wait_ready();
        if (e_exc) begin
            exp_exc++;
        end else begin
            b.we = !ld; b.addr = {addr[31:2], 2'b00}; b.be = e_be;
            b.wdata = e_wdata; b.chk_wdata = !ld;
            exp_bus.push_back(b);
            if (ld) begin
                w.rd = rdn; w.data = e_ld;
                exp_wb.push_back(w);
            end
        end
        issue(ld, f3, addr, wdata, rdn);
        @(negedge clk);
        if (e_exc) begin
            chk("exc_ready_held", req_ready, 1);
            chk("exc_req_low", mem_req, 0);
            return;
        end
        chk("ready_low_req", req_ready, 0);
        s_addr = mem_addr; s_wdata = mem_wdata; s_be = mem_be;
        for (int i = 0; i < gnt_dly; i++) begin
            @(negedge clk);
            chk("hold_req", mem_req, 1);
            chk("hold_addr", mem_addr, s_addr);
            chk("hold_be", mem_be, s_be);
            chk("hold_wdata", mem_wdata, s_wdata);
            chk("hold_ready_low", req_ready, 0);
        end
        mem_gnt = 1'b1;
        @(posedge clk);
        #1 mem_gnt = 1'b0;
        @(negedge clk);
        chk("req_drop_after_gnt", mem_req, 0);
        chk("ready_low_wait", req_ready, 0);
        for (int i = 0; i < rv_dly; i++) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(posedge clk);
        #1 mem_rvalid = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        chk("ready_after_resp", req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_ld_data", ld_data, 0);
        chk("rst_exc", exc, 0);
        reset = 1'b0;

        //     ld f3  addr        wdata        rd gnt rv rdata        exc be    e_wdata      e_ld
        do_op(1, 2, 32'h100, 32'h0,        5, 0, 1, 32'hDEADBEEF, 0, 4'hF, 32'h0,        32'hDEADBEEF);
        do_op(1, 0, 32'h103, 32'h0,        6, 0, 0, 32'h80FF0000, 0, 4'h8, 32'h0,        32'hFFFFFF80);
        do_op(1, 4, 32'h103, 32'h0,        7, 1, 0, 32'h80FF0000, 0, 4'h8, 32'h0,        32'h00000080);
        do_op(0, 1, 32'h202, 32'h1234ABCD, 0, 0, 1, 32'h0,        0, 4'hC, 32'hABCDABCD, 32'h0);
        do_op(1, 2, 32'h101, 32'h0,        3, 0, 0, 32'h0,        1, 4'h0, 32'h0,        32'h0);
        do_op(1, 1, 32'h102, 32'h0,        8, 5, 2, 32'h80011234, 0, 4'hC, 32'h0,        32'hFFFF8001);
        do_op(1, 5, 32'h100, 32'h0,        9, 0, 0, 32'h8001F00F, 0, 4'h3, 32'h0,        32'h0000F00F);
        do_op(0, 0, 32'h101, 32'h000000A5, 0, 2, 0, 32'h0,        0, 4'h2, 32'hA5A5A5A5, 32'h0);
        do_op(0, 2, 32'h300, 32'hCAFEF00D, 0, 5, 1, 32'h0,        0, 4'hF, 32'hCAFEF00D, 32'h0);
        do_op(1, 3, 32'h100, 32'h0,        4, 0, 0, 32'h0,        1, 4'h0, 32'h0,        32'h0);
        do_op(0, 4, 32'h100, 32'h55,       0, 0, 0, 32'h0,        1, 4'h0, 32'h0,        32'h0);
        do_op(1, 1, 32'h101, 32'h0,        4, 0, 0, 32'h0,        1, 4'h0, 32'h0,        32'h0);
        do_op(0, 2, 32'h302, 32'h1,        0, 0, 0, 32'h0,        1, 4'h0, 32'h0,        32'h0);
        do_op(1, 2, 32'h104, 32'h0,        0, 0, 0, 32'h11223344, 0, 4'hF, 32'h0,        32'h11223344);
        do_op(1, 0, 32'h101, 32'h0,        31, 0, 0, 32'h00007F00, 0, 4'h2, 32'h0,       32'h0000007F);

        // Abort a load in WAIT with reset; the late response must be ignored.
        begin
            bus_t b;
            wait_ready();
            b.we = 1'b0; b.addr = 32'h400; b.be = 4'hF; b.wdata = '0; b.chk_wdata = 1'b0;
            exp_bus.push_back(b);
            issue(1, 2, 32'h400, 32'h0, 10);
            @(negedge clk);
            mem_gnt = 1'b1;
            @(posedge clk);
            #1 mem_gnt = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("abort_req_ready", req_ready, 0);
            chk("abort_mem_req", mem_req, 0);
            chk("abort_mem_be", mem_be, 0);
            chk("abort_mem_addr", mem_addr, 0);
            chk("abort_wr_en", wr_en, 0);
            chk("abort_rd", rd, 0);
            chk("abort_is_load", is_load, 0);
            reset = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h55555555;
            @(posedge clk);
            #1 mem_rvalid = 1'b0;
            mem_rdata = '0;
            @(negedge clk);
            chk("abort_idle_ready", req_ready, 1);
            chk("abort_no_wr_en", wr_en, 0);
            chk("abort_no_req", mem_req, 0);
        end

        do_op(1, 0, 32'h103, 32'h0, 12, 1, 1, 32'h7F000000, 0, 4'h8, 32'h0, 32'h0000007F);

        repeat (5) @(negedge clk);
        chk("bus_queue_empty", exp_bus.size(), 0);
        chk("wb_queue_empty", exp_wb.size(), 0);
        chk("exc_pending_zero", exp_exc, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the RISC-V core, between execute and the register-file write port. Accepts one load or store per transaction from execute (effective address, store data, destination register), drives a single-outstanding word-aligned memory bus, and returns aligned, sign/zero-extended load data as a one-cycle writeback pulse (`wr_en`/`rd`/`ld_data`/`is_load`). Stores produce no writeback.

## Interface
- `width`, 32: data/address width; only 32 supported.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: execute presents a memory op.
- `req_ready` out 1: LSU can accept; high only in IDLE.
- `req_is_load` in 1: 1 = load, 0 = store.
- `req_funct3` in 3: RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW).
- `req_addr` in width: effective address (ALU result).
- `req_wdata` in width: store data (rs2 value).
- `req_rd` in 5: load destination.
- `mem_req` out 1: bus request, held until `mem_gnt`.
- `mem_we` out 1: 1 = write.
- `mem_addr` out width: `{req_addr[31:2], 2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out width: lane-replicated store data.
- `mem_gnt` in 1: request accepted.
- `mem_rvalid` in 1: response (read data or write ack).
- `mem_rdata` in width: read data.
- `wr_en` out 1: one-cycle writeback pulse (loads only).
- `rd` out 5: writeback destination.
- `ld_data` out width: formatted load data.
- `is_load` out 1: high with every `wr_en`.
- `exc` out 1: one-cycle pulse, misaligned or illegal funct3.

## Operation
- FSM: IDLE -> REQ on accept of a legal op; REQ -> WAIT on `mem_gnt`; WAIT -> IDLE on `mem_rvalid`. `mem_rvalid` ignored outside WAIT; `mem_gnt` ignored outside REQ.
- Accept = `req_valid && req_ready`; addr offset, funct3, rd, is_load latched.
- Illegal: load funct3 3/6/7, store funct3 >= 3, halfword with `addr[0]`=1, word with `addr[1:0]`!=0 -> `exc` pulse, no bus access, no `wr_en`, FSM stays IDLE.
- `mem_be`: byte `4'b0001 << off`; half `4'b0011 << off`; word `4'hF`. Same for loads and stores.
- `mem_wdata`: SB `{4{wdata[7:0]}}`, SH `{2{wdata[15:0]}}`, SW `wdata`.
- Load format: `s = mem_rdata >> (8*off)`; LB sext `s[7:0]`, LBU zext `s[7:0]`, LH sext `s[15:0]`, LHU zext `s[15:0]`, LW `s`.
- `rd`=0 loads perform the access and pulse `wr_en` with `rd`=0 (regfile discards).
- Reset: all outputs 0, FSM to IDLE; a late `mem_rvalid` from an aborted access is ignored.

## Timing
- All outputs registered.
- Accept at cycle T -> `mem_req`=1 from T+1 (or `exc`=1 at T+1, `req_ready` stays 1).
- `mem_req`/`mem_we`/`mem_addr`/`mem_be`/`mem_wdata` stable from T+1 until the `mem_gnt` cycle G; `mem_req`=0 at G+1.
- `mem_rvalid` at R (R >= G+1) -> load: `wr_en`/`is_load`=1, `rd`, `ld_data` valid at R+1 only; `req_ready`=1 at R+1.
- Back-to-back: new accept possible at R+1, its `mem_req` at R+2.
- `req_ready`=0 from T+1 through R.

## Structure
- `lsu_pkg`: funct3 localparams (`F3_LB`..`F3_SW`), `lsu_state_t` enum {IDLE, REQ, WAIT}, `be_for()` function.
- Sub-module `lsu_load_align`: combinational funct3/offset/rdata -> formatted `ld_data`.

## Test plan
- LW addr 0x100, gnt at T+1, rdata 0xDEADBEEF at T+3 -> mem_addr 0x100, be 0xF, T+4 wr_en=1, ld_data 0xDEADBEEF.
- LB addr 0x103, rdata 0x80FF_0000 -> be 0x8, ld_data 0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x202, wdata 0x1234ABCD -> mem_we=1, be 0xC, mem_wdata 0xABCDABCD, no wr_en.
- LW addr 0x101 -> exc pulse at T+1, mem_req never high, req_ready high.
- mem_gnt withheld 5 cycles -> mem_req and bus fields stable, req_ready low throughout.
- reset asserted in WAIT, then mem_rvalid -> all outputs 0, no wr_en, FSM IDLE.
